// File: rtl/bkg_bank_scheduler.sv
// Background bank display controller: scrolled read addressing, a frame-paced wipe
// between banks, and write gating of visible banks. Vertical scroll needs BKG_SCROLL_EN.
module bkg_bank_scheduler #(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 160,
  parameter int VIS_ROWS  = 120,
  parameter int WIPE_STEP = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        vblank,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [3:0]  scroll_amt,
  input  logic [1:0]  bank_req,
  output logic [14:0] read_address,
  input  logic [23:0] ram_data0,
  input  logic [23:0] ram_data1,
  input  logic [23:0] ram_data2,
  input  logic [23:0] ram_data3,
  output logic [23:0] bkg_rgb,
  output logic [1:0]  cur_bank,
  output logic        busy,
  input  logic        wr_req,
  input  logic [1:0]  wr_bank,
  input  logic [14:0] wr_addr,
  input  logic [4:0]  wr_data,
  output logic        wr_ack,
  output logic [3:0]  we,
  output logic [14:0] write_address,
  output logic [4:0]  data_In
);

  localparam logic [0:0] SHOW = 1'b0;
  localparam logic [0:0] WIPE = 1'b1;

  localparam logic [8:0] IMG_H_C = 9'(IMG_H);
  localparam logic [7:0] VIS_C   = 8'(VIS_ROWS);
  localparam logic [7:0] STEP_C  = 8'(WIPE_STEP);

  logic [0:0]  state_r;
  logic [7:0]  wipe_row_r;
  logic [1:0]  tgt_bank_r;
  logic [1:0]  cur_bank_r;
  logic [1:0]  sel1_r;
  logic [1:0]  sel2_r;
  logic [14:0] read_address_r;
  logic [23:0] bkg_rgb_r;

  logic [7:0]  scroll_off_s;
  logic [7:0]  vy_s;
  logic [7:0]  x_s;
  logic [8:0]  row_sum_s;
  logic [7:0]  row_s;
  logic [14:0] addr_s;
  logic [1:0]  sel_s;
  logic [7:0]  wipe_next_s;
  logic [23:0] pix_s;
  logic        visible_s;
  logic        grant_s;
  logic        unused_s;

`ifdef BKG_SCROLL_EN
  logic [7:0] scroll_off_r;
  logic [8:0] scroll_sum_s;

  assign scroll_sum_s = {1'b0, scroll_off_r} + {5'd0, scroll_amt};

  // Advance the scroll offset once per frame, wrapping at the image height
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scroll_off_r <= 8'd0;
    end else if (frame_start) begin
      scroll_off_r <= (scroll_sum_s >= IMG_H_C) ? (scroll_sum_s[7:0] - IMG_H_C[7:0])
                                                : scroll_sum_s[7:0];
    end else begin
      scroll_off_r <= scroll_off_r;
    end
  end

  assign scroll_off_s = scroll_off_r;
  assign unused_s     = ^{DrawX[1:0], DrawY[1:0]};
`else
  assign scroll_off_s = 8'd0;
  assign unused_s     = ^{DrawX[1:0], DrawY[1:0], scroll_amt};
`endif

  assign wipe_next_s = wipe_row_r + STEP_C;

  // Pixel coordinate to bank address and bank selection for the current pixel
  always_comb begin
    vy_s      = DrawY[9:2];
    x_s       = DrawX[9:2];
    row_sum_s = {1'b0, vy_s} + {1'b0, scroll_off_s};
    // Sum is below twice the image height, so one conditional subtract wraps it
    if (row_sum_s >= IMG_H_C) begin
      row_s = row_sum_s[7:0] - IMG_H_C[7:0];
    end else begin
      row_s = row_sum_s[7:0];
    end
    if (IMG_W == 160) begin
      addr_s = {row_s, 7'd0} + {2'd0, row_s, 5'd0} + {7'd0, x_s};
    end else begin
      addr_s = 15'(int'(row_s) * IMG_W) + {7'd0, x_s};
    end
    if ((state_r == WIPE) && (vy_s < wipe_row_r)) begin
      sel_s = tgt_bank_r;
    end else begin
      sel_s = cur_bank_r;
    end
  end

  // Frame-paced wipe sequencer; requests arriving mid-wipe wait for SHOW
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= SHOW;
      wipe_row_r <= 8'd0;
      tgt_bank_r <= 2'd0;
      cur_bank_r <= 2'd0;
    end else if (frame_start) begin
      case (state_r)
        SHOW: begin
          if (bank_req != cur_bank_r) begin
            tgt_bank_r <= bank_req;
            wipe_row_r <= 8'd0;
            state_r    <= WIPE;
          end
        end
        WIPE: begin
          if (wipe_next_s >= VIS_C) begin
            cur_bank_r <= tgt_bank_r;
            wipe_row_r <= 8'd0;
            state_r    <= SHOW;
          end else begin
            wipe_row_r <= wipe_next_s;
          end
        end
        default: state_r <= SHOW;
      endcase
    end
  end

  // Selected bank's data lands one cycle after the address, so the select trails it
  always_comb begin
    case (sel2_r)
      2'd0:    pix_s = ram_data0;
      2'd1:    pix_s = ram_data1;
      2'd2:    pix_s = ram_data2;
      2'd3:    pix_s = ram_data3;
      default: pix_s = ram_data0;
    endcase
  end

  // Three-stage read pipeline: address, RAM access, pixel register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address_r <= 15'd0;
      sel1_r         <= 2'd0;
      sel2_r         <= 2'd0;
      bkg_rgb_r      <= 24'd0;
    end else begin
      read_address_r <= addr_s;
      sel1_r         <= sel_s;
      sel2_r         <= sel1_r;
      bkg_rgb_r      <= pix_s;
    end
  end

  // Visible banks only accept writes during vertical blanking
  always_comb begin
    visible_s = (wr_bank == cur_bank_r) || ((state_r == WIPE) && (wr_bank == tgt_bank_r));
    grant_s   = wr_req && !Reset && (!visible_s || vblank);
    if (grant_s) begin
      we            = 4'b0001 << wr_bank;
      write_address = wr_addr;
      data_In       = wr_data;
    end else begin
      we            = 4'b0000;
      write_address = 15'd0;
      data_In       = 5'd0;
    end
  end

  assign wr_ack       = grant_s;
  assign read_address = read_address_r;
  assign bkg_rgb      = bkg_rgb_r;
  assign cur_bank     = cur_bank_r;
  assign busy         = (state_r == WIPE);

endmodule

// File: doc/bkg_bank_scheduler.md
# bkg_bank_scheduler

Display-side controller for the four background RAM banks (each 25600 x 24-bit, 160 x 160 image, 15-bit addresses, one-cycle registered read). Each pixel clock it turns VGA `DrawX`/`DrawY` into a vertically scrolled bank read address and returns the selected bank's pixel. At frame boundaries it sequences a top-down wipe from the current bank to a requested bank. It also gates the shared write port so a visible bank is only written during vertical blanking.

## Interface
- `IMG_W`, 160, image width in pixels
- `IMG_H`, 160, image height in rows; scroll modulus
- `VIS_ROWS`, 120, displayed image rows (`DrawY>>2` range)
- `WIPE_STEP`, 4, rows the wipe line advances per frame
- `Clk`  in  1  system/pixel clock
- `Reset`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse at start of vertical blank
- `vblank`  in  1  high during vertical blanking
- `DrawX`, `DrawY`  in  10 each  current VGA pixel coordinates
- `scroll_amt`  in  4  rows to scroll per frame
- `bank_req`  in  2  requested background bank
- `read_address`  out  15  shared read address to all four banks
- `ram_data0`..`ram_data3`  in  24 each  bank `data_Out` values
- `bkg_rgb`  out  24  selected background pixel
- `cur_bank`  out  2  bank currently shown
- `busy`  out  1  high while a wipe is in progress
- `wr_req`  in  1  writer request; held until acknowledged
- `wr_bank`  in  2  target bank
- `wr_addr`  in  15  target address
- `wr_data`  in  5  write data
- `wr_ack`  out  1  one-cycle grant; write issued that cycle
- `we`  out  4  one-hot bank write enables
- `write_address`  out  15  write address passed to the banks
- `data_In`  out  5  write data passed to the banks

## Operation
- Coordinate mapping:
  - `x = DrawX>>2` (0..159), `vy = DrawY>>2` (0..119).
  - `row = (vy + scroll_off) mod IMG_H`.
  - `read_address = row*160 + x`, computed as `(row<<7)+(row<<5)+x`. Maximum is 25599.
- `scroll_off` (8-bit, 0..159):
  - On `frame_start`, `scroll_off <= (scroll_off + scroll_amt) mod 160`.
  - The wrap is a single conditional subtract.
- FSM states:
  - SHOW:
    - On `frame_start` with `bank_req != cur_bank`, latch `tgt_bank = bank_req`, set `wipe_row = 0`, go to WIPE.
    - Otherwise stay in SHOW.
  - WIPE:
    - Pixels with `vy < wipe_row` use `tgt_bank`; all others use `cur_bank`.
    - On each `frame_start`, `wipe_row += WIPE_STEP`.
    - When the new value is `>= VIS_ROWS`: `cur_bank <= tgt_bank`, go to SHOW.
    - `bank_req` changes during WIPE are ignored. A still-different request starts a new wipe at the first `frame_start` in SHOW.
- `busy` = (state == WIPE).
- Write gating:
  - A bank is visible if it equals `cur_bank`, or equals `tgt_bank` while in WIPE.
  - `wr_req` to a non-visible bank is granted immediately.
  - `wr_req` to a visible bank is granted only while `vblank` = 1.
  - On grant, in the same cycle: `wr_ack = 1`, `we = 1<<wr_bank`, and `write_address`/`data_In` driven from `wr_addr`/`wr_data`.
  - At most one write per cycle. With `wr_req` held, grants repeat each eligible cycle; the writer drops `wr_req` or advances after `wr_ack`.
- Reset values:
  - Outputs: `read_address=0`, `bkg_rgb=0`, `cur_bank=0`, `busy=0`, `wr_ack=0`, `we=0`, `write_address=0`, `data_In=0`.
  - Internal: state SHOW, `scroll_off=0`, `wipe_row=0`, `tgt_bank=0`.
- Reset mid-wipe aborts the wipe. Bank 0 is shown and `tgt_bank` is discarded.

## Timing
- Read pipeline, with `DrawX`/`DrawY` sampled at cycle t:
  - t+1: `read_address` registered, and the bank select is registered alongside it.
  - t+2: RAM data valid; bank select delayed one more stage.
  - t+3: `bkg_rgb` registered.
  - Total latency 3 cycles, fully pipelined, one pixel per cycle.
- `frame_start` cycle:
  - `scroll_off`, `wipe_row`, state and `cur_bank` update at the end of that cycle.
  - Addresses computed from the next cycle onward use the new values.
  - Pixels already in the pipeline finish with the old selection.
- `frame_start` and `wr_req` in the same cycle: gating uses the pre-update `cur_bank`/`tgt_bank`.
- `wr_ack`/`we` are combinational from `wr_req`, `wr_bank`, `vblank` and registered state. There are no added cycles.

## Configuration
- `BKG_SCROLL_EN` defined: scrolling as described.
- `BKG_SCROLL_EN` undefined:
  - `scroll_off` is constant 0 and `scroll_amt` is ignored, so `row = vy`.
  - Timing and all other behaviour are unchanged.

## Test plan
- Reset, then `DrawX=4`, `DrawY=8`, `scroll_off=0` -> `read_address=321` at t+1, `bkg_rgb=ram_data0` value at t+3, `busy=0`.
- Scroll wrap: `scroll_off=158`, `scroll_amt=5`, one `frame_start` -> `scroll_off=3`. `DrawY=0`, `DrawX=0` -> `read_address=480`.
- Wipe: `bank_req=2`, `frame_start` -> `busy=1`. After 30 further `frame_start` pulses -> `cur_bank=2`, `busy=0`. Mid-wipe with `wipe_row=40`: `DrawY=156` (vy=39) selects bank 2, `DrawY=160` (vy=40) selects bank 0.
- Write gating:
  - `cur_bank=0`, `wr_req`, `wr_bank=0`, `vblank=0` -> `wr_ack=0`, `we=0`.
  - Raise `vblank` -> `wr_ack=1`, `we=4'b0001`.
  - `wr_bank=3` with `vblank=0` -> immediate `wr_ack`, `we=4'b1000`.
- `Reset` asserted during WIPE with `wipe_row=60` -> next cycle `cur_bank=0`, `busy=0`, `scroll_off=0`, all outputs at reset values.
- With `BKG_SCROLL_EN` undefined: `scroll_amt=7` for 3 frames -> `read_address` for `DrawY=0`, `DrawX=0` stays 0.
